// File: rtl/hilo_md_ctrl.sv
// Multiply/divide sequencer and HI/LO register owner.
// Issues mul/div to external units, stalls ID while busy, and serves mfhi/mflo/mthi/mtlo.
module hilo_md_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [53:0] id_instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hilo_rdata,
    output logic        rd_we,
    output logic [31:0] rd_wdata,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_prod,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_abort,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi;
    logic [31:0]   lo;

    logic is_divu, is_div, is_mul, is_mulu, is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic issue;

    assign is_divu = id_instr[32];
    assign is_div  = id_instr[33];
    assign is_mul  = id_instr[34];
    assign is_mulu = id_instr[35];
    assign is_mfhi = id_instr[46];
    assign is_mthi = id_instr[47];
    assign is_mflo = id_instr[48];
    assign is_mtlo = id_instr[49];

    // Decoder bits owned by other units are deliberately ignored here.
    logic unused_instr;
    assign unused_instr = ^{id_instr[53:50], id_instr[45:36], id_instr[31:0]};

    assign issue = (state == S_IDLE) && id_valid && !flush;
    assign stall = (state != S_IDLE);

    always_comb begin
        hilo_rdata = '0;
        if (is_mfhi)
            hilo_rdata = hi;
        else if (is_mflo)
            hilo_rdata = lo;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            rd_we      <= 1'b0;
            rd_wdata   <= '0;
            mul_start  <= 1'b0;
            mul_signed <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_abort  <= 1'b0;
        end else begin
            // Pulse outputs default low so each one lasts exactly one cycle.
            mul_start <= 1'b0;
            div_start <= 1'b0;
            rd_we     <= 1'b0;
            div_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (is_divu || is_div) begin
                            if (rt_data != '0) begin
                                div_a      <= rs_data;
                                div_b      <= rt_data;
                                div_signed <= !is_divu;
                                div_start  <= 1'b1;
                                state      <= S_DIV;
                            end else begin
                                lo <= 32'hFFFF_FFFF;
                                hi <= rs_data;
                            end
                        end else if (is_mul || is_mulu) begin
                            mul_a      <= rs_data;
                            mul_b      <= rt_data;
                            mul_signed <= is_mul;
                            mul_start  <= 1'b1;
                            cnt        <= CW'(MUL_LAT - 1);
                            state      <= S_MUL;
                        end else if (is_mthi) begin
                            hi <= rs_data;
                        end else if (is_mtlo) begin
                            lo <= rs_data;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_IDLE;
                        if (mul_signed) begin
                            rd_wdata <= mul_prod[31:0];
                            rd_we    <= 1'b1;
                        end else begin
                            {hi, lo} <= mul_prod;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        div_abort <= 1'b1;
                    end else if (div_done) begin
                        lo    <= div_q;
                        hi    <= div_r;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl: behavioural mul/div units, a HI/LO reference model and a
// scoreboard that checks every rd write and every mfhi/mflo read the DUT presents.
module tb_hilo_md_ctrl;

    localparam int MUL_LAT = 3;
    localparam int BOUND   = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [53:0] id_instr;
    logic [31:0] rs_data, rt_data;
    logic        flush;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        mul_start, mul_signed;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_prod;
    logic        div_start, div_signed;
    logic [31:0] div_a, div_b;
    logic        div_abort, div_done;
    logic [31:0] div_q, div_r;

    always #5 clk = ~clk;

    hilo_md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .stall(stall),
        .hilo_rdata(hilo_rdata), .rd_we(rd_we), .rd_wdata(rd_wdata),
        .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
        .mul_prod(mul_prod), .div_start(div_start), .div_signed(div_signed),
        .div_a(div_a), .div_b(div_b), .div_abort(div_abort), .div_done(div_done),
        .div_q(div_q), .div_r(div_r)
    );

    typedef enum {OP_NONE, OP_DIVU, OP_DIV, OP_MUL, OP_MULU, OP_MTHI, OP_MTLO} op_e;
    typedef struct { bit is_rd; logic [31:0] val; } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          div_lat = 5;
    bit          stray_done = 0;
    int          expect_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic bail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait exceeded %0d cycles", name, BOUND);
        summary_and_finish();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic op_e decode(input logic [53:0] ins);
        if (ins[32]) return OP_DIVU;
        if (ins[33]) return OP_DIV;
        if (ins[34]) return OP_MUL;
        if (ins[35]) return OP_MULU;
        if (ins[47]) return OP_MTHI;
        if (ins[49]) return OP_MTLO;
        return OP_NONE;
    endfunction

    // Multiplier: garbage in the start cycle, the true product from then on.
    bit mpend = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mpend = 0;
        end else if (mul_start) begin
            mpend    = 1;
            mul_prod = {$urandom, $urandom};
        end else if (mpend) begin
            if (mul_signed)
                mul_prod = longint'($signed(mul_a)) * longint'($signed(mul_b));
            else
                mul_prod = 64'(mul_a) * 64'(mul_b);
        end
    end

    // Divider: done div_lat+1 cycles after the start cycle; dropped on abort.
    bit          dbusy = 0;
    int          dcnt;
    logic [31:0] da, db;
    bit          ds;
    always @(negedge clk) begin
        longint sa, sb;
        div_done = 1'b0;
        div_q    = $urandom;
        div_r    = $urandom;
        if (!rst_n || div_abort) dbusy = 0;
        if (stray_done) begin
            div_done   = 1'b1;
            stray_done = 0;
        end else if (div_start) begin
            dbusy = 1; dcnt = div_lat; da = div_a; db = div_b; ds = div_signed;
        end else if (dbusy) begin
            if (dcnt == 0) begin
                div_done = 1'b1;
                dbusy    = 0;
                if (ds) begin
                    sa    = longint'($signed(da));
                    sb    = longint'($signed(db));
                    div_q = 32'(sa / sb);
                    div_r = 32'(sa % sb);
                end else begin
                    div_q = da / db;
                    div_r = da % db;
                end
            end else begin
                dcnt--;
            end
        end
    end

    // Monitor: rd writes first, then any mfhi/mflo read issued this cycle.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (rd_we) begin
                if (sb_q.size() == 0 || !sb_q[0].is_rd) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_we_unexpected: got write 0x%0h, expected none", rd_wdata);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rd_wdata", rd_wdata, mon_e.val);
                end
            end
            if (id_valid && !stall && (id_instr[46] || id_instr[48])) begin
                if (sb_q.size() == 0 || sb_q[0].is_rd) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL hilo_read_order: got read 0x%0h, expected pending rd write or nothing", hilo_rdata);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("hilo_rdata", hilo_rdata, mon_e.val);
                end
            end
        end
    end

    // Present one instruction, hold it through any stall, then apply the model.
    task automatic run(input logic [53:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input int flush_at, input bit flush_on_done);
        op_e         op = decode(ins);
        int          w = 0;
        logic [63:0] prod;
        longint      sa, sb;
        id_valid = 1'b1; id_instr = ins; rs_data = rs; rt_data = rt; flush = 1'b0;
        while (stall) begin
            step();
            w++;
            if (w > BOUND) bail("stall_release");
        end
        check("stall_cycles", 64'(w), 64'(expect_stall));
        expect_stall = 0;
        if (ins[46])      sb_q.push_back('{is_rd: 0, val: m_hi});
        else if (ins[48]) sb_q.push_back('{is_rd: 0, val: m_lo});
        step();
        id_valid = 1'b0; id_instr = '0;
        case (op)
            OP_DIVU, OP_DIV: begin
                if (rt == '0) begin
                    check("div0_no_start", div_start, 0);
                    check("div0_no_stall", stall, 0);
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = rs;
                end else begin
                    check("div_start", div_start, 1);
                    check("div_signed", div_signed, (op == OP_DIV));
                    check("div_operands", {div_a, div_b}, {rs, rt});
                    if (flush_on_done || flush_at >= 0) begin
                        w = 0;
                        while (flush_on_done ? !div_done : (w < flush_at)) begin
                            step();
                            w++;
                            if (w > BOUND) bail("div_done_wait");
                        end
                        flush = 1'b1;
                        step();
                        flush = 1'b0;
                        check("div_abort_pulse", div_abort, 1);
                        check("flush_idle", stall, 0);
                        step();
                        check("div_abort_end", div_abort, 0);
                    end else begin
                        if (op == OP_DIV) begin
                            sa = longint'($signed(rs));
                            sb = longint'($signed(rt));
                            m_lo = 32'(sa / sb);
                            m_hi = 32'(sa % sb);
                        end else begin
                            m_lo = rs / rt;
                            m_hi = rs % rt;
                        end
                        expect_stall = div_lat + 2;
                    end
                end
            end
            OP_MUL, OP_MULU: begin
                check("mul_start", mul_start, 1);
                check("mul_signed", mul_signed, (op == OP_MUL));
                check("mul_operands", {mul_a, mul_b}, {rs, rt});
                check("mul_stall", stall, 1);
                if (flush_at >= 0) begin
                    repeat (flush_at) step();
                    flush = 1'b1;
                    step();
                    flush = 1'b0;
                    check("flush_idle", stall, 0);
                end else begin
                    if (op == OP_MUL) begin
                        prod = longint'($signed(rs)) * longint'($signed(rt));
                        sb_q.push_back('{is_rd: 1, val: prod[31:0]});
                    end else begin
                        prod = 64'(rs) * 64'(rt);
                        {m_hi, m_lo} = prod;
                    end
                    expect_stall = MUL_LAT;
                end
            end
            OP_MTHI: begin m_hi = rs; check("mthi_no_stall", stall, 0); end
            OP_MTLO: begin m_lo = rs; check("mtlo_no_stall", stall, 0); end
            default: check("nop_no_stall", stall, 0);
        endcase
    endtask

    function automatic logic [53:0] bit_ins(input int b);
        logic [53:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [53:0] rand_ins();
        logic [53:0] v;
        v = 54'({$urandom, $urandom});
        v[35:32] = '0;
        v[49:46] = '0;
        for (int b = 32; b <= 35; b++) if ($urandom_range(0, 4) == 0) v[b] = 1'b1;
        for (int b = 46; b <= 49; b++) if ($urandom_range(0, 3) == 0) v[b] = 1'b1;
        if (v[46]) v[48] = 1'b0;
        return v;
    endfunction

    initial begin
        logic [53:0] ins;
        logic [31:0] rs, rt;
        int          fa;
        bit          fd;
        op_e         op;
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; rs_data = '0; rt_data = '0; flush = 1'b0;
        repeat (3) step();
        check("rst_stall", stall, 0);
        check("rst_pulses", {rd_we, mul_start, div_start, div_abort}, 0);
        check("rst_signed", {mul_signed, div_signed}, 0);
        check("rst_regs", {mul_a, mul_b, div_a, div_b}, 0);
        check("rst_rd_wdata", rd_wdata, 0);
        rst_n = 1'b1;
        step();
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);

        run(bit_ins(47), 32'h1234, 0, -1, 0);
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(35), 32'hFFFF_FFFF, 2, -1, 0);
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);
        div_lat = 31;
        run(bit_ins(33), 32'hFFFF_FFF9, 2, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(32), 32'h55, 0, -1, 0);
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);
        run(bit_ins(34), 6, 7, -1, 0);
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);
        div_lat = 10;
        run(bit_ins(32), 32'd1000, 32'd7, -1, 1);
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);
        stray_done = 1;
        repeat (2) step();
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);

        for (int i = 0; i < 300; i++) begin
            ins = rand_ins();
            rs  = $urandom;
            rt  = ($urandom_range(0, 3) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            div_lat = $urandom_range(0, 40);
            op = decode(ins);
            fa = -1;
            fd = 0;
            if ((op == OP_MUL || op == OP_MULU) && $urandom_range(0, 4) == 0)
                fa = $urandom_range(0, MUL_LAT - 1);
            if ((op == OP_DIV || op == OP_DIVU) && rt != 0) begin
                if ($urandom_range(0, 9) == 0)      fd = 1;
                else if ($urandom_range(0, 4) == 0) fa = $urandom_range(0, div_lat + 1);
            end
            run(ins, rs, rt, fa, fd);
        end
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);

        run('0, 0, 0, -1, 0);
        id_valid = 1'b1; id_instr = bit_ins(34); rs_data = 32'd9; rt_data = 32'd9;
        step();
        id_valid = 1'b0; id_instr = '0;
        check("mul_busy_before_reset", stall, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", stall, 0);
        check("async_rst_pulses", {rd_we, mul_start, div_start, div_abort}, 0);
        check("async_rst_regs", {mul_signed, mul_a, mul_b}, 0);
        step();
        check("rst_no_rd_we", rd_we, 0);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        expect_stall = 0;
        step();
        run(bit_ins(46), 0, 0, -1, 0);
        run(bit_ins(48), 0, 0, -1, 0);
        repeat (2) step();
        check("scoreboard_drained", 64'(sb_q.size()), 0);
        summary_and_finish();
    end

endmodule
